// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall/flush controller for the 5-stage OTTER pipeline.
// Define HAZARD_PERF_EN to build the stall/flush performance counters.
module hazard_stall_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [4:0]       ID_RS1,
   input  logic [4:0]       ID_RS2,
   input  logic             ID_RS1_USED,
   input  logic             ID_RS2_USED,
   input  logic [4:0]       EX_RD,
   input  logic             EX_MEM_READ,
   input  logic             BR_TAKEN,
   input  logic             MEM_BUSY,
   output logic             PC_STALL,
   output logic             IF_ID_STALL,
   output logic             ID_EX_BUBBLE,
   output logic             IF_ID_FLUSH,
   output logic             EX_MEM_STALL,
   output logic             LD_HAZ,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_LD_STALL,
      ST_LD_FWD,
      ST_FLUSH,
      ST_MEM_WAIT
   } state_e;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_e     state_q, state_d;
   state_e     saved_q, saved_d;
   logic [3:0] flush_cnt_q, flush_cnt_d;

   logic ld_use;
   logic pc_stall_c, if_id_stall_c, id_ex_bubble_c, if_id_flush_c, ex_mem_stall_c, ld_haz_c;

   // A load into x0 never produces a value worth waiting for.
   assign ld_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                   ((ID_RS1_USED && (ID_RS1 == EX_RD)) ||
                    (ID_RS2_USED && (ID_RS2 == EX_RD)));

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d        = state_q;
      saved_d        = saved_q;
      flush_cnt_d    = flush_cnt_q;
      pc_stall_c     = 1'b0;
      if_id_stall_c  = 1'b0;
      id_ex_bubble_c = 1'b0;
      if_id_flush_c  = 1'b0;
      ex_mem_stall_c = 1'b0;
      ld_haz_c       = 1'b0;

      if (MEM_BUSY) begin
         pc_stall_c     = 1'b1;
         if_id_stall_c  = 1'b1;
         ex_mem_stall_c = 1'b1;
         state_d        = ST_MEM_WAIT;
         if (state_q != ST_MEM_WAIT) saved_d = state_q;
      end else begin
         case (state_q)
            ST_RUN, ST_LD_FWD: begin
               ld_haz_c = (state_q == ST_LD_FWD);
               // A taken branch makes the ID instruction wrong-path, so it masks ld_use.
               if (BR_TAKEN) begin
                  if_id_flush_c  = 1'b1;
                  id_ex_bubble_c = 1'b1;
                  flush_cnt_d    = FLUSH_LOAD;
                  state_d        = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
               end else if (ld_use) begin
                  pc_stall_c     = 1'b1;
                  if_id_stall_c  = 1'b1;
                  id_ex_bubble_c = 1'b1;
                  state_d        = ST_LD_STALL;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_LD_STALL: state_d = ST_LD_FWD;
            ST_FLUSH: begin
               if_id_flush_c = 1'b1;
               if (flush_cnt_q <= 4'd1) begin
                  flush_cnt_d = 4'd0;
                  state_d     = ST_RUN;
               end else begin
                  flush_cnt_d = flush_cnt_q - 4'd1;
               end
            end
            ST_MEM_WAIT: state_d = saved_q;
            default:     state_d = ST_RUN;
         endcase
      end
   end

   // Outputs are forced low while reset is asserted, independent of the inputs.
   assign PC_STALL     = RST_N & pc_stall_c;
   assign IF_ID_STALL  = RST_N & if_id_stall_c;
   assign ID_EX_BUBBLE = RST_N & id_ex_bubble_c;
   assign IF_ID_FLUSH  = RST_N & if_id_flush_c;
   assign EX_MEM_STALL = RST_N & ex_mem_stall_c;
   assign LD_HAZ       = RST_N & ld_haz_c;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= ST_RUN;
         saved_q     <= ST_RUN;
         flush_cnt_q <= 4'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops sample together.
         state_q     <= state_d;
         saved_q     <= saved_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic             br_accept;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_evt_q, flush_evt_d;

   assign br_accept = !MEM_BUSY && BR_TAKEN &&
                      ((state_q == ST_RUN) || (state_q == ST_LD_FWD));

   always_comb begin
      stall_cnt_d = stall_cnt_q + (pc_stall_c ? CNT_W'(1) : CNT_W'(0));
      flush_evt_d = flush_evt_q + (br_accept  ? CNT_W'(1) : CNT_W'(0));
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stall_cnt_q <= '0;
         flush_evt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_evt_q <= flush_evt_d;
      end
   end

   assign STALL_CNT = stall_cnt_q;
   assign FLUSH_CNT = flush_evt_q;
`else
   assign STALL_CNT = '0;
   assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (FLUSH_CYCLES=2).
// Output vector order: {PC_STALL, IF_ID_STALL, ID_EX_BUBBLE, IF_ID_FLUSH, EX_MEM_STALL, LD_HAZ}.
module tb_hazard_stall_ctrl;

   localparam int CNT_W = 32;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic [4:0]       ID_RS1, ID_RS2, EX_RD;
   logic             ID_RS1_USED, ID_RS2_USED, EX_MEM_READ, BR_TAKEN, MEM_BUSY;
   logic             PC_STALL, IF_ID_STALL, ID_EX_BUBBLE, IF_ID_FLUSH, EX_MEM_STALL, LD_HAZ;
   logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;

   int checks   = 0;
   int failures = 0;

   hazard_stall_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
      .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
      .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ),
      .BR_TAKEN(BR_TAKEN), .MEM_BUSY(MEM_BUSY),
      .PC_STALL(PC_STALL), .IF_ID_STALL(IF_ID_STALL), .ID_EX_BUBBLE(ID_EX_BUBBLE),
      .IF_ID_FLUSH(IF_ID_FLUSH), .EX_MEM_STALL(EX_MEM_STALL), .LD_HAZ(LD_HAZ),
      .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {26'd0, PC_STALL, IF_ID_STALL, ID_EX_BUBBLE, IF_ID_FLUSH, EX_MEM_STALL, LD_HAZ};
   endfunction

   task automatic drv(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic [4:0] rd, input logic mr, input logic br, input logic busy);
      ID_RS1 = rs1; ID_RS2 = rs2; ID_RS1_USED = u1; ID_RS2_USED = u2;
      EX_RD = rd; EX_MEM_READ = mr; BR_TAKEN = br; MEM_BUSY = busy;
   endtask

   task automatic idle();
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Inputs are driven just after a rising edge; outputs checked 1 ns later, then advance one cycle.
   task automatic step(input string tag, input logic [5:0] exp);
      #1;
      check(tag, outs(), {26'd0, exp});
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // Reset with hazard-provoking inputs: every output must stay low.
      RST_N = 1'b0;
      drv(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      #2;
      check("rst_outs", outs(), 32'd0);
      check("rst_stall_cnt", STALL_CNT, 32'd0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      idle();
      step("idle", 6'b000000);

      // lw x5 / add x6,x5,x1: stall, bubble cycle, then LD_HAZ.
      drv(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); step("lu_c0", 6'b111000);
      drv(5'd5, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); step("lu_c1", 6'b000000);
      idle();                                               step("lu_c2", 6'b000001);
      idle();                                               step("lu_c3", 6'b000000);

      // Load to x0 never stalls; unused rs2 never stalls.
      drv(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); step("x0_c0", 6'b000000);
      idle();                                               step("x0_c1", 6'b000000);
      drv(5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); step("rs2_unused", 6'b000000);

      // rs2 hazard followed by a back-to-back hazard evaluated in LD_FWD.
      drv(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); step("rs2_c0", 6'b111000);
      idle();                                               step("rs2_c1", 6'b000000);
      drv(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); step("b2b_c2", 6'b111001);
      idle();                                               step("b2b_c3", 6'b000000);
      idle();                                               step("b2b_c4", 6'b000001);
      idle();                                               step("b2b_c5", 6'b000000);

      // Taken branch masks a simultaneous load-use; second branch in FLUSH ignored.
      drv(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0); step("br_c0", 6'b001100);
      drv(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0); step("br_c1", 6'b000100);
      idle();                                               step("br_c2", 6'b000000);

      // Memory freeze for three cycles during LD_STALL.
      drv(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); step("mb_c0", 6'b111000);
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); step("mb_c1", 6'b110010);
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); step("mb_c2", 6'b110010);
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); step("mb_c3", 6'b110010);
      idle();                                               step("mb_c4", 6'b000000);
      idle();                                               step("mb_c5", 6'b000000);
      idle();                                               step("mb_c6", 6'b000001);
      idle();                                               step("mb_c7", 6'b000000);

      // MEM_BUSY outranks BR_TAKEN; freeze in FLUSH holds the flush counter.
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); step("mbbr_c0", 6'b110010);
      idle();                                               step("mbbr_c1", 6'b000000);
      idle();                                               step("mbbr_c2", 6'b000000);
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step("fz_c0", 6'b001100);
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); step("fz_c1", 6'b110010);
      idle();                                               step("fz_c2", 6'b000000);
      idle();                                               step("fz_c3", 6'b000100);
      idle();                                               step("fz_c4", 6'b000000);

      // Reset asserted mid-FLUSH: outputs drop at once, RUN after release.
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step("rf_c0", 6'b001100);
      idle();
      #1;
      check("rf_flush_before_rst", outs(), 32'b000100);
      RST_N = 1'b0;
      #1;
      check("rf_rst_outs", outs(), 32'd0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      idle();                                               step("rf_post_idle", 6'b000000);

      // Performance scenario after a fresh reset: 2 load-use stalls, 1 taken branch.
      RST_N = 1'b0;
      #1;
      RST_N = 1'b1;
      drv(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); step("pf_lu1", 6'b111000);
      idle();                                               step("pf_lu1_s", 6'b000000);
      idle();                                               step("pf_lu1_f", 6'b000001);
      drv(5'd0, 5'd6, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); step("pf_lu2", 6'b111000);
      idle();                                               step("pf_lu2_s", 6'b000000);
      idle();                                               step("pf_lu2_f", 6'b000001);
      drv(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); step("pf_br", 6'b001100);
      idle();                                               step("pf_fl", 6'b000100);
      idle();                                               step("pf_end", 6'b000000);
`ifdef HAZARD_PERF_EN
      check("stall_cnt", STALL_CNT, 32'd2);
      check("flush_cnt", FLUSH_CNT, 32'd1);
`else
      check("stall_cnt_tied", STALL_CNT, 32'd0);
      check("flush_cnt_tied", FLUSH_CNT, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
